// File: rtl/itlb_refill_unit.sv
// itlb_refill_unit
//   Fully associative instruction micro-TLB with a JTLB refill engine.
//   The fetch-stage lookup is answered combinationally in the same cycle.
//   A mapped miss fetches the entry from the CP0 JTLB and then writes it into a victim slot.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   lookup_req/lookup_vaddr/cur_asid fetch lookup request, virtual address and current ASID
//   flush                            invalidate all entries (TLB write or ASID change)
//   itlb_found/index/pfn/c/d/v       same-cycle hit result (all zero on a miss or in kseg0/kseg1)
//   itlb_stall                       refill in progress; IF holds lookup_vaddr
//   jtlb_req/jtlb_vpn/jtlb_asid      refill request toward the JTLB, held until jtlb_ack
//   jtlb_ack/found/index/pfn/c/d/v/g JTLB response (single-cycle ack)
module itlb_refill_unit #(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              lookup_req,
  input  logic [31:0]       lookup_vaddr,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              flush,
  output logic              itlb_found,
  output logic [3:0]        itlb_index,
  output logic [19:0]       itlb_pfn,
  output logic [2:0]        itlb_c,
  output logic              itlb_d,
  output logic              itlb_v,
  output logic              itlb_stall,
  output logic              jtlb_req,
  output logic [19:0]       jtlb_vpn,
  output logic [ASID_W-1:0] jtlb_asid,
  input  logic              jtlb_ack,
  input  logic              jtlb_found,
  input  logic [3:0]        jtlb_index,
  input  logic [19:0]       jtlb_pfn,
  input  logic [2:0]        jtlb_c,
  input  logic              jtlb_d,
  input  logic              jtlb_v,
  input  logic              jtlb_g
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL, MISS} state_t;

  state_t state, state_next;
  logic   discard, discard_next;
  logic   capture, write_en;

  logic [ENTRIES-1:0] ent_valid;
  logic [19:0]        ent_vpn  [ENTRIES];
  logic [ASID_W-1:0]  ent_asid [ENTRIES];
  logic               ent_g    [ENTRIES];
  logic [19:0]        ent_pfn  [ENTRIES];
  logic [2:0]         ent_c    [ENTRIES];
  logic               ent_d    [ENTRIES];
  logic               ent_v    [ENTRIES];
  logic [3:0]         ent_jidx [ENTRIES];

  // JTLB response held from the ack cycle until the FILL cycle writes it
  logic [19:0] fill_pfn;
  logic [2:0]  fill_c;
  logic        fill_d, fill_v, fill_g;
  logic [3:0]  fill_jidx;

  logic [IDX_W-1:0] rr, victim, hit_idx;
  logic             use_rr, hit, mapped;

  // The page offset never takes part in translation
  logic unused_vaddr_bits;
  assign unused_vaddr_bits = ^lookup_vaddr[11:0];

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) are unmapped and bypass the TLB entirely
  assign mapped = (lookup_vaddr[31:28] <= 4'h7) || (lookup_vaddr[31:28] >= 4'hC);

  // Associative match; the lowest matching slot wins if duplicates ever exist
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && ent_valid[i] && (ent_vpn[i] == lookup_vaddr[31:12]) &&
          (ent_g[i] || (ent_asid[i] == cur_asid))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign itlb_found = mapped && hit;
  assign itlb_index = itlb_found ? ent_jidx[hit_idx] : 4'd0;
  assign itlb_pfn   = itlb_found ? ent_pfn[hit_idx]  : 20'd0;
  assign itlb_c     = itlb_found ? ent_c[hit_idx]    : 3'd0;
  assign itlb_d     = itlb_found && ent_d[hit_idx];
  assign itlb_v     = itlb_found && ent_v[hit_idx];

  // Victim: lowest-index invalid slot, else the round-robin pointer
  always_comb begin
    victim = rr;
    use_rr = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        victim = IDX_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  // Next-state logic. A flush seen in REQ is remembered in discard so the later ack is
  // swallowed; a flush coincident with the ack is treated the same way.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    capture      = 1'b0;
    write_en     = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_req && mapped && !hit) begin
          state_next = REQ;
          capture    = 1'b1;
        end
      end
      REQ: begin
        if (flush) discard_next = 1'b1;
        if (jtlb_ack) begin
          discard_next = 1'b0;
          if (discard || flush) state_next = IDLE;
          else if (jtlb_found)  state_next = FILL;
          else                  state_next = MISS;
        end
      end
      FILL: begin
        write_en   = !flush;
        state_next = IDLE;
      end
      MISS: begin
        if (flush || !(lookup_req && (lookup_vaddr[31:12] == jtlb_vpn)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign jtlb_req   = (state == REQ);
  assign itlb_stall = (state == REQ) || (state == FILL);

  // Control state, valid bits and the captured request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      discard   <= 1'b0;
      rr        <= '0;
      ent_valid <= '0;
      jtlb_vpn  <= '0;
      jtlb_asid <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (capture) begin
        jtlb_vpn  <= lookup_vaddr[31:12];
        jtlb_asid <= cur_asid;
      end
      if (flush) begin
        ent_valid <= '0;
      end else if (write_en) begin
        ent_valid[victim] <= 1'b1;
      end
      if (write_en && use_rr) rr <= rr + 1'b1;
    end
  end

  // Entry payload and response holding registers; only meaningful once qualified by valid/state
  always_ff @(posedge clk) begin
    if (state == REQ && jtlb_ack) begin
      fill_pfn  <= jtlb_pfn;
      fill_c    <= jtlb_c;
      fill_d    <= jtlb_d;
      fill_v    <= jtlb_v;
      fill_g    <= jtlb_g;
      fill_jidx <= jtlb_index;
    end
    if (write_en) begin
      ent_vpn[victim]  <= jtlb_vpn;
      ent_asid[victim] <= jtlb_asid;
      ent_g[victim]    <= fill_g;
      ent_pfn[victim]  <= fill_pfn;
      ent_c[victim]    <= fill_c;
      ent_d[victim]    <= fill_d;
      ent_v[victim]    <= fill_v;
      ent_jidx[victim] <= fill_jidx;
    end
  end

endmodule
